// File: rtl/wb_cmd_master_if.sv
// Command/response and Wishbone classic bus bundle for wb_cmd_master.
//
// Optional: WB_CMD_MASTER_ERR_EN adds wbm_err_i (slave bus error input).
//
// Signals:
//   req_*  : valid/ready command port (we, adr, dat, sel) into the master
//   rsp_*  : valid/ready response port (dat, err) out of the master
//   wbm_*  : Wishbone B4 classic master-side signals
// Modports:
//   master : the wb_cmd_master side
//   slave  : the environment side (command source, response sink, WB slave)
interface wb_cmd_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_adr;
    logic [DATA_W-1:0]     req_dat;
    logic [DATA_W/8-1:0]   req_sel;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_dat;
    logic                  rsp_err;

    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [ADDR_W-1:0]     wbm_adr_o;
    logic [DATA_W-1:0]     wbm_dat_o;
    logic [DATA_W/8-1:0]   wbm_sel_o;
    logic [DATA_W-1:0]     wbm_dat_i;
    logic                  wbm_ack_i;
`ifdef WB_CMD_MASTER_ERR_EN
    logic                  wbm_err_i;
`endif

    modport master (
`ifdef WB_CMD_MASTER_ERR_EN
        input  wbm_err_i,
`endif
        input  req_valid, req_we, req_adr, req_dat, req_sel,
        input  rsp_ready,
        input  wbm_dat_i, wbm_ack_i,
        output req_ready,
        output rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
`ifdef WB_CMD_MASTER_ERR_EN
        output wbm_err_i,
`endif
        output req_valid, req_we, req_adr, req_dat, req_sel,
        output rsp_ready,
        output wbm_dat_i, wbm_ack_i,
        input  req_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer master. Accepts one command on the
// valid/ready request port, runs one Wishbone cycle, and returns read data or
// write completion on the valid/ready response port. A cycle counter aborts
// transfers to slaves that never acknowledge (TIMEOUT_CYC = 0 disables it).
//
// Optional: define WB_CMD_MASTER_ERR_EN to honour wbm_err_i (err beats ack).
//
// Ports:
//   wb_clk_i   : clock
//   wb_rst_n_i : asynchronous active-low reset
//   bus        : wb_cmd_master_if.master (request, response, Wishbone)
//   busy       : high whenever the master is not idle
//
// All outputs come from registers or are decoded from the state register;
// nothing combinational runs from an input to an output.
// TIMEOUT_CYC must be below 2**CNT_W.
module wb_cmd_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    wb_cmd_master_if.master bus,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // Value of the counter on the last permitted stb cycle.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

    state_e                state_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     adr_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic [DATA_W-1:0]     rsp_dat_q;
    logic                  rsp_err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic bus_err;
    logic timeout_hit;

`ifdef WB_CMD_MASTER_ERR_EN
    assign bus_err = bus.wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TimeoutLast);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        adr_q   <= bus.req_adr;
                        dat_q   <= bus.req_dat;
                        sel_q   <= bus.req_sel;
                        cnt_q   <= '0;
                        state_q <= StBus;
                    end
                end
                StBus: begin
                    // Priority: bus error, then ack, then timeout expiry.
                    if (bus_err) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                        state_q   <= StResp;
                    end else if (bus.wbm_ack_i) begin
                        rsp_dat_q <= we_q ? '0 : bus.wbm_dat_i;
                        rsp_err_q <= 1'b0;
                        state_q   <= StResp;
                    end else if (timeout_hit) begin
                        rsp_dat_q <= '0;
                        rsp_err_q <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = (state_q == StBus);
    assign bus.wbm_stb_o = (state_q == StBus);
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (TIMEOUT_CYC = 8). Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_wb_cmd_master;

    logic clk;
    logic rst_n;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    // Command currently being issued, used to check the held bus values.
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    wb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_cmd_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8),
        .CNT_W       (4)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a command at a falling edge; returns one cycle later, in BUS.
    task automatic start_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        cmd_we  = we;
        cmd_adr = adr;
        cmd_dat = dat;
        cmd_sel = sel;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
        bus.req_sel   = sel;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_adr   = 32'hFFFF_FFFF;
        bus.req_dat   = 32'hFFFF_FFFF;
    endtask

    // Act as the slave: ack (and optionally err) on the given stb cycle,
    // 0 = never. Counts stb cycles; returns at the first falling edge with
    // stb low. hold_ok clears if bus values or req_ready misbehave in BUS.
    task automatic run_slave(input int ack_cyc, input int err_cyc, input logic [31:0] rdata,
                             output int stb_cycles, output logic hold_ok);
        stb_cycles = 0;
        hold_ok    = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (!bus.wbm_stb_o) break;
            stb_cycles++;
            if (!bus.wbm_cyc_o || bus.req_ready || !busy || bus.rsp_valid ||
                bus.wbm_we_o !== cmd_we || bus.wbm_adr_o !== cmd_adr ||
                bus.wbm_dat_o !== cmd_dat || bus.wbm_sel_o !== cmd_sel)
                hold_ok = 1'b0;
            bus.wbm_dat_i = rdata;
            if (i == ack_cyc) bus.wbm_ack_i = 1'b1;
`ifdef WB_CMD_MASTER_ERR_EN
            if (i == err_cyc) bus.wbm_err_i = 1'b1;
`else
            if (i == err_cyc) hold_ok = 1'b0;
`endif
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
`ifdef WB_CMD_MASTER_ERR_EN
            bus.wbm_err_i = 1'b0;
`endif
            bus.wbm_dat_i = 32'hBAD0_BAD0;
        end
    endtask

    // Consume the response in the current cycle and check the return to idle.
    task automatic take_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq({tag, "_idle_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({tag, "_idle_req_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    int          stb_n;
    logic        hold;
    logic [31:0] held_dat;
    logic        stable;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wbm_dat_i = '0;
        bus.wbm_ack_i = 1'b0;
`ifdef WB_CMD_MASTER_ERR_EN
        bus.wbm_err_i = 1'b0;
`endif
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_cyc",       64'(bus.wbm_cyc_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_busy",      64'(busy),          64'd0);
        check_eq("rst_adr",       64'(bus.wbm_adr_o), 64'd0);
        check_eq("rst_rsp_dat",   64'(bus.rsp_dat),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, zero-wait slave; read data on the bus must not leak into rsp_dat.
        start_cmd(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF);
        run_slave(1, 0, 32'hFFFF_FFFF, stb_n, hold);
        check_eq("wr_stb_cycles", 64'(stb_n),         64'd1);
        check_eq("wr_hold",       64'(hold),          64'd1);
        check_eq("wr_rsp_valid",  64'(bus.rsp_valid), 64'd1);
        check_eq("wr_rsp_err",    64'(bus.rsp_err),   64'd0);
        check_eq("wr_rsp_dat",    64'(bus.rsp_dat),   64'd0);
        take_rsp("wr");

        // Read with 3 wait states.
        start_cmd(1'b0, 32'h3000_0004, 32'h0000_0011, 4'h3);
        run_slave(4, 0, 32'h0000_0005, stb_n, hold);
        check_eq("rd3_stb_cycles", 64'(stb_n),         64'd4);
        check_eq("rd3_hold",       64'(hold),          64'd1);
        check_eq("rd3_rsp_valid",  64'(bus.rsp_valid), 64'd1);
        check_eq("rd3_rsp_err",    64'(bus.rsp_err),   64'd0);
        check_eq("rd3_rsp_dat",    64'(bus.rsp_dat),   64'd5);
        take_rsp("rd3");

        // Timeout: slave never acks.
        start_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        run_slave(0, 0, 32'h7777_7777, stb_n, hold);
        check_eq("to_stb_cycles", 64'(stb_n),         64'd8);
        check_eq("to_hold",       64'(hold),          64'd1);
        check_eq("to_rsp_valid",  64'(bus.rsp_valid), 64'd1);
        check_eq("to_rsp_err",    64'(bus.rsp_err),   64'd1);
        check_eq("to_rsp_dat",    64'(bus.rsp_dat),   64'd0);
        take_rsp("to");

        // Next command after a timeout completes normally.
        start_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        run_slave(2, 0, 32'h0000_00C3, stb_n, hold);
        check_eq("post_to_stb_cycles", 64'(stb_n),       64'd2);
        check_eq("post_to_rsp_err",    64'(bus.rsp_err), 64'd0);
        check_eq("post_to_rsp_dat",    64'(bus.rsp_dat), 64'hC3);
        take_rsp("post_to");

        // Ack on the expiry cycle wins over the timeout.
        start_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        run_slave(8, 0, 32'hCAFE_F00D, stb_n, hold);
        check_eq("edge_stb_cycles", 64'(stb_n),       64'd8);
        check_eq("edge_rsp_err",    64'(bus.rsp_err), 64'd0);
        check_eq("edge_rsp_dat",    64'(bus.rsp_dat), 64'hCAFE_F00D);
        take_rsp("edge");

        // Response backpressure with a new command already waiting.
        start_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        run_slave(1, 0, 32'h1234_5678, stb_n, hold);
        held_dat = bus.rsp_dat;
        check_eq("bp_rsp_dat", 64'(held_dat), 64'h1234_5678);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 32'h3000_0018;
        bus.req_dat   = 32'h0000_0042;
        bus.req_sel   = 4'h1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!bus.rsp_valid || bus.rsp_dat !== 32'h1234_5678 || bus.req_ready ||
                bus.wbm_cyc_o)
                stable = 1'b0;
            @(negedge clk);
        end
        check_eq("bp_stable",    64'(stable),        64'd1);
        check_eq("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("bp_idle_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("bp_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        cmd_we = 1'b1; cmd_adr = 32'h3000_0018; cmd_dat = 32'h0000_0042; cmd_sel = 4'h1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("bp_next_cyc", 64'(bus.wbm_cyc_o), 64'd1);
        run_slave(1, 0, 32'h5555_5555, stb_n, hold);
        check_eq("bp_next_hold",    64'(hold),        64'd1);
        check_eq("bp_next_rsp_dat", 64'(bus.rsp_dat), 64'd0);
        take_rsp("bp_next");

        // Stray ack in IDLE produces no transfer or response.
        bus.wbm_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("stray_busy",      64'(busy),          64'd0);
        bus.wbm_ack_i = 1'b0;

        // Asynchronous reset while in BUS.
        start_cmd(1'b0, 32'h3000_001C, 32'h0, 4'hF);
        check_eq("mid_cyc_before", 64'(bus.wbm_cyc_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cyc",       64'(bus.wbm_cyc_o), 64'd0);
        check_eq("mid_rst_stb",       64'(bus.wbm_stb_o), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("mid_rel_cyc",       64'(bus.wbm_cyc_o), 64'd0);

        // Asynchronous reset discards a pending response.
        start_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        run_slave(1, 0, 32'h0000_0099, stb_n, hold);
        check_eq("rrsp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rrsp_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rrsp_rel_req_ready", 64'(bus.req_ready), 64'd1);

`ifdef WB_CMD_MASTER_ERR_EN
        // Err and ack together on the 2nd cycle: err wins.
        start_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        run_slave(2, 2, 32'hAAAA_AAAA, stb_n, hold);
        check_eq("err_stb_cycles", 64'(stb_n),         64'd2);
        check_eq("err_rsp_valid",  64'(bus.rsp_valid), 64'd1);
        check_eq("err_rsp_err",    64'(bus.rsp_err),   64'd1);
        check_eq("err_rsp_dat",    64'(bus.rsp_dat),   64'd0);
        take_rsp("err");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
